// File: rtl/eeg_out_serializer.sv
// Splits accelerator result words into output-buffer beats, LSB beat first,
// keeping frame boundaries on ACC_OUT_LST and counting completed frames.
//
//   state | meaning
//   IDLE  | no word held; RES_RDY=1
//   SEND  | word held in shift_q; presenting beat beat_cnt on ACC_OUT_*
module eeg_out_serializer #(
    parameter int RES_DW      = 32,
    parameter int CHIP_OUT_DW = 8,
    parameter int FRM_CW      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   RES_VLD,
    input  logic                   RES_LST,
    output logic                   RES_RDY,
    input  logic [RES_DW-1:0]      RES_DAT,
    output logic                   ACC_OUT_VLD,
    output logic                   ACC_OUT_LST,
    input  logic                   ACC_OUT_RDY,
    output logic [CHIP_OUT_DW-1:0] ACC_OUT_DAT,
    output logic                   BUSY,
    output logic [FRM_CW-1:0]      FRM_CNT
);

    localparam int BEATS = RES_DW / CHIP_OUT_DW;
    localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            state;
    logic [RES_DW-1:0] shift_q;
    logic [RES_DW-1:0] shift_nxt;
    logic              lst_q;
    logic [BCW-1:0]    beat_cnt;
    logic              last_beat;
    logic              beat_acc;
    logic              word_acc;

    // With a single beat per word there is nothing left to shift down.
    generate
        if (BEATS > 1) begin : g_shift
            assign shift_nxt = {{CHIP_OUT_DW{1'b0}}, shift_q[RES_DW-1:CHIP_OUT_DW]};
        end else begin : g_noshift
            assign shift_nxt = '0;
        end
    endgenerate

    assign last_beat = (beat_cnt == LAST_BEAT);
    assign beat_acc  = (state == SEND) && ACC_OUT_RDY;

    // Accepting the next word on the final-beat handshake avoids a bubble.
    assign RES_RDY  = !rst && ((state == IDLE) || (beat_acc && last_beat));
    assign word_acc = RES_VLD && RES_RDY;

    assign ACC_OUT_VLD = (state == SEND);
    assign ACC_OUT_DAT = shift_q[CHIP_OUT_DW-1:0];
    assign ACC_OUT_LST = (state == SEND) && lst_q && last_beat;
    assign BUSY        = (state == SEND);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shift_q  <= '0;
            lst_q    <= 1'b0;
            beat_cnt <= '0;
            FRM_CNT  <= '0;
        end else begin
            if (beat_acc && ACC_OUT_LST) begin
                FRM_CNT <= FRM_CNT + FRM_CW'(1);
            end
            if (word_acc) begin
                shift_q  <= RES_DAT;
                lst_q    <= RES_LST;
                beat_cnt <= '0;
                state    <= SEND;
            end else if (beat_acc) begin
                if (last_beat) begin
                    state <= IDLE;
                end else begin
                    shift_q  <= shift_nxt;
                    beat_cnt <= beat_cnt + BCW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_eeg_out_serializer.sv
// Directed bench for eeg_out_serializer: a beat-queue model checks instance A every
// cycle; literal expectations pin the directed scenarios on instances A, B and C.
module tb_eeg_out_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // instance A: 32 -> 8, FRM_CW 16
    logic        a_vld, a_lst, a_rdy, a_ovld, a_olst, a_ordy, a_busy;
    logic [31:0] a_dat;
    logic [7:0]  a_odat;
    logic [15:0] a_frm;

    // instance B: 32 -> 8, FRM_CW 4
    logic        b_vld, b_lst, b_rdy, b_ovld, b_olst, b_ordy, b_busy;
    logic [31:0] b_dat;
    logic [7:0]  b_odat;
    logic [3:0]  b_frm;

    // instance C: 32 -> 32 (single beat per word)
    logic        c_vld, c_lst, c_rdy, c_ovld, c_olst, c_ordy, c_busy;
    logic [31:0] c_dat;
    logic [31:0] c_odat;
    logic [15:0] c_frm;

    eeg_out_serializer #(.RES_DW(32), .CHIP_OUT_DW(8), .FRM_CW(16)) dut_a (
        .clk(clk), .rst(rst),
        .RES_VLD(a_vld), .RES_LST(a_lst), .RES_RDY(a_rdy), .RES_DAT(a_dat),
        .ACC_OUT_VLD(a_ovld), .ACC_OUT_LST(a_olst), .ACC_OUT_RDY(a_ordy), .ACC_OUT_DAT(a_odat),
        .BUSY(a_busy), .FRM_CNT(a_frm)
    );

    eeg_out_serializer #(.RES_DW(32), .CHIP_OUT_DW(8), .FRM_CW(4)) dut_b (
        .clk(clk), .rst(rst),
        .RES_VLD(b_vld), .RES_LST(b_lst), .RES_RDY(b_rdy), .RES_DAT(b_dat),
        .ACC_OUT_VLD(b_ovld), .ACC_OUT_LST(b_olst), .ACC_OUT_RDY(b_ordy), .ACC_OUT_DAT(b_odat),
        .BUSY(b_busy), .FRM_CNT(b_frm)
    );

    eeg_out_serializer #(.RES_DW(32), .CHIP_OUT_DW(32), .FRM_CW(16)) dut_c (
        .clk(clk), .rst(rst),
        .RES_VLD(c_vld), .RES_LST(c_lst), .RES_RDY(c_rdy), .RES_DAT(c_dat),
        .ACC_OUT_VLD(c_ovld), .ACC_OUT_LST(c_olst), .ACC_OUT_RDY(c_ordy), .ACC_OUT_DAT(c_odat),
        .BUSY(c_busy), .FRM_CNT(c_frm)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Model: every accepted word becomes four pending beats; the front beat is what
    // must be on the output, and the queue length alone decides BUSY and RES_RDY.
    typedef struct {
        logic [7:0] d;
        logic       l;
    } beat_t;

    beat_t      exp_q[$];
    beat_t      m_b;
    int         m_frm = 0;
    bit         mon_en = 0;
    bit         m_pend;
    bit         m_rdy;
    int         in_cyc_log[$];
    int         out_cyc_log[$];
    logic [7:0] out_dat_log[$];
    logic       out_lst_log[$];

    always @(negedge clk) begin
        if (mon_en) begin
            m_pend = (exp_q.size() != 0);
            m_rdy  = !rst && (exp_q.size() == 0 || (exp_q.size() == 1 && a_ordy));
            check("busy", a_busy, m_pend);
            check("out_vld", a_ovld, m_pend);
            if (m_pend) begin
                check("out_dat", a_odat, exp_q[0].d);
                check("out_lst", a_olst, exp_q[0].l);
            end
            check("frm_cnt", a_frm, 16'(m_frm));
            check("res_rdy", a_rdy, m_rdy);
            if (rst) begin
                exp_q.delete();
                m_frm = 0;
            end else begin
                if (m_pend && a_ordy) begin
                    m_b = exp_q.pop_front();
                    if (m_b.l) m_frm = (m_frm + 1) % 65536;
                    out_cyc_log.push_back(cyc);
                    out_dat_log.push_back(a_odat);
                    out_lst_log.push_back(a_olst);
                end
                if (a_vld && m_rdy) begin
                    in_cyc_log.push_back(cyc);
                    for (int k = 0; k < 4; k++) begin
                        m_b.d = a_dat[8*k +: 8];
                        m_b.l = a_lst && (k == 3);
                        exp_q.push_back(m_b);
                    end
                end
            end
        end
    end

    task automatic clear_logs();
        in_cyc_log.delete();
        out_cyc_log.delete();
        out_dat_log.delete();
        out_lst_log.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic push_word(input logic [31:0] d, input logic l);
        bit done;
        done  = 0;
        a_vld = 1'b1;
        a_dat = d;
        a_lst = l;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (a_rdy) done = 1;
            @(posedge clk);
            #1;
        end
        a_vld = 1'b0;
        if (!done) check("push_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (!a_busy) done = 1;
        end
        @(posedge clk);
        #1;
        if (!done) check("idle_timeout", 0, 1);
    endtask

    logic [7:0]  e1[4];
    logic [7:0]  e2[8];
    logic [31:0] c_w[4];
    bit          c_l[4];
    int          nwords;
    bit          bdone;

    initial begin
        rst = 1'b1;
        a_vld = 0; a_lst = 0; a_dat = '0; a_ordy = 1;
        b_vld = 0; b_lst = 0; b_dat = '0; b_ordy = 1;
        c_vld = 0; c_lst = 0; c_dat = '0; c_ordy = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_vld", a_ovld, 0);
        check("rst_dat", a_odat, 0);
        check("rst_lst", a_olst, 0);
        check("rst_rdy", a_rdy, 0);
        rst = 1'b0;
        mon_en = 1;

        // single word, one frame
        do_reset();
        e1 = '{8'h11, 8'h22, 8'h33, 8'h44};
        push_word(32'h44332211, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("t1_busy_end", a_busy, 0);
        check("t1_frm", a_frm, 1);
        check("t1_nbeats", out_dat_log.size(), 4);
        for (int k = 0; k < 4; k++) begin
            check("t1_dat", out_dat_log[k], e1[k]);
            check("t1_lst", out_lst_log[k], k == 3);
            check("t1_cyc", out_cyc_log[k] - in_cyc_log[0], k + 1);
        end

        // two words back to back, no gap between them
        do_reset();
        e2 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01, 8'h02, 8'h03, 8'h04};
        push_word(32'hDDCCBBAA, 1'b0);
        push_word(32'h04030201, 1'b1);
        wait_idle();
        check("t2_nbeats", out_dat_log.size(), 8);
        for (int k = 0; k < 8; k++) begin
            check("t2_dat", out_dat_log[k], e2[k]);
            check("t2_lst", out_lst_log[k], k == 7);
            check("t2_cyc", out_cyc_log[k] - out_cyc_log[0], k);
        end
        check("t2_frm", a_frm, 1);

        // output stall while 0x22 is presented
        do_reset();
        push_word(32'h44332211, 1'b1);
        @(posedge clk);
        #1;
        a_ordy = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("t3_hold_dat", a_odat, 8'h22);
            check("t3_hold_vld", a_ovld, 1);
        end
        @(posedge clk);
        #1;
        a_ordy = 1'b1;
        wait_idle();
        check("t3_nbeats", out_dat_log.size(), 4);
        for (int k = 0; k < 4; k++) check("t3_dat", out_dat_log[k], e1[k]);

        // reset mid-word discards remaining beats
        do_reset();
        push_word(32'h44332211, 1'b1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t4_vld", a_ovld, 0);
        check("t4_dat", a_odat, 0);
        check("t4_frm", a_frm, 0);
        check("t4_busy", a_busy, 0);
        push_word(32'h88776655, 1'b1);
        wait_idle();
        check("t4_nbeats", out_dat_log.size(), 6);
        check("t4_pre0", out_dat_log[0], 8'h11);
        check("t4_pre1", out_dat_log[1], 8'h22);
        check("t4_first", out_dat_log[2], 8'h55);
        check("t4_last", out_dat_log[5], 8'h88);
        check("t4_frm_after", a_frm, 1);

        // frame counter wrap with a 4-bit counter
        do_reset();
        nwords = 0;
        b_vld = 1'b1;
        b_lst = 1'b1;
        for (int i = 0; i < 200 && nwords < 17; i++) begin
            b_dat = 32'h01010101 * (i + 1);
            @(negedge clk);
            if (b_rdy) nwords++;
            @(posedge clk);
            #1;
        end
        b_vld = 1'b0;
        check("t5_words", nwords, 17);
        bdone = 0;
        for (int i = 0; i < 20 && !bdone; i++) begin
            @(negedge clk);
            if (!b_busy) bdone = 1;
        end
        if (!bdone) check("t5_idle_timeout", 0, 1);
        check("t5_frm", b_frm, 4'd1);

        // one beat per word, full throughput
        do_reset();
        c_w = '{32'hA1B2C3D4, 32'h0BADF00D, 32'h12345678, 32'hCAFEF00D};
        c_l = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                c_vld = 1'b1;
                c_dat = c_w[i];
                c_lst = c_l[i];
            end else begin
                c_vld = 1'b0;
            end
            @(negedge clk);
            if (i < 4) check("t6_res_rdy", c_rdy, 1);
            if (i >= 1 && i <= 4) begin
                check("t6_vld", c_ovld, 1);
                check("t6_dat", c_odat, c_w[i-1]);
                check("t6_lst", c_olst, c_l[i-1]);
            end
            if (i == 5) check("t6_idle", c_ovld, 0);
            @(posedge clk);
            #1;
        end
        check("t6_frm", c_frm, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
